// File: rtl/readout_sequencer_pkg.sv
// readout_sequencer_pkg
//   Shared definitions for the readout sequencer: FSM state encoding,
//   header bit positions, record length, post-record hold length and the
//   header byte builder.
//   No ports (package).
package readout_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    UNLOAD = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam int OVR_BIT      = 7;
  localparam int REC_BIT      = 6;
  localparam int RECORD_BYTES = 8;
  localparam int HOLD_CYCLES  = 2;

  // Header layout: [7]=overrun-only, [6]=full record follows, [5:0]=channel.
  function automatic logic [7:0] make_header(input logic ovr, input logic [5:0] idx);
    logic [7:0] h;
    h          = {2'b00, idx};
    h[OVR_BIT] = ovr;
    h[REC_BIT] = ~ovr;
    return h;
  endfunction

endpackage

// File: rtl/readout_sequencer_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin search: starting at 'pointer', walks the
//   attention vector upward modulo NUM_CHANNELS and reports the first set
//   channel.
//   Ports:
//     attention [NUM_CHANNELS] in  : per-channel request
//     pointer   [CHAN_W]       in  : first channel to consider (< NUM_CHANNELS)
//     grant     [CHAN_W]       out : winning channel index (0 when none)
//     found                    out : any request present
module rr_arbiter #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_W       = 2
) (
  input  logic [NUM_CHANNELS-1:0] attention,
  input  logic [CHAN_W-1:0]       pointer,
  output logic [CHAN_W-1:0]       grant,
  output logic                    found
);

  // cand[k] is the channel examined k-th in search order.
  logic [CHAN_W-1:0] cand [NUM_CHANNELS];

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_cand
    assign cand[gi] = (int'(pointer) + gi >= NUM_CHANNELS)
                    ? CHAN_W'(int'(pointer) + gi - NUM_CHANNELS)
                    : CHAN_W'(int'(pointer) + gi);
  end

  // Scan from the far end so the nearest candidate is written last and wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (attention[cand[k]]) begin
        grant = cand[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// readout_sequencer
//   Round-robin grants one attentive event-logger channel and serialises its
//   timestamp record (header + 8 data bytes) onto a valid/ready byte stream.
//   Issues the per-channel unload / clearoverrun strobes and drives the
//   shared byteaddr bus.
//   Optional build macro READOUT_CHECKSUM_EN: appends one trailer byte (XOR of
//   every byte of the record) before unload / overrun clear.
//   Ports:
//     clk, rstn (async, active-low)
//     attention[N], overrun[N]  in  : channel flags
//     chandata[8N]              in  : channel i byte at [8i+7:8i]
//     byteaddr[3]               out : byte select to all channels
//     unload[N], clearoverrun[N] out: one-cycle one-hot strobes
//     outbyte[8], outvalid      out : stream byte / valid
//     outready                  in  : sink accepts byte
//     busy                      out : not in IDLE
module readout_sequencer
  import readout_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CHAN_W       = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_CHANNELS-1:0]   attention,
  input  logic [NUM_CHANNELS-1:0]   overrun,
  input  logic [8*NUM_CHANNELS-1:0] chandata,
  output logic [2:0]                byteaddr,
  output logic [NUM_CHANNELS-1:0]   unload,
  output logic [NUM_CHANNELS-1:0]   clearoverrun,
  output logic [7:0]                outbyte,
  output logic                      outvalid,
  input  logic                      outready,
  output logic                      busy
);

  localparam logic [2:0] LAST_ADDR = 3'(RECORD_BYTES - 1);

  state_t                  state_reg, state_next;
  logic [CHAN_W-1:0]       grant_reg, rr_ptr_reg;
  logic [CHAN_W-1:0]       arb_grant, rr_ptr_next;
  logic                    arb_found;
  logic [2:0]              byteaddr_reg;
  logic [NUM_CHANNELS-1:0] clear_reg;
  logic [NUM_CHANNELS-1:0] grant_onehot;
  logic [1:0]              hold_cnt_reg;
  logic [7:0]              chan_bytes [NUM_CHANNELS];
  logic [7:0]              cur_byte;
  logic [7:0]              header_byte;
  logic                    cur_ovr;
  logic                    xfer;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]              csum_reg;
  logic                    ovr_rec_reg;
`endif

  rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CHAN_W       (CHAN_W)
  ) u_arb (
    .attention (attention),
    .pointer   (rr_ptr_reg),
    .grant     (arb_grant),
    .found     (arb_found)
  );

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    assign chan_bytes[gi]   = chandata[8*gi +: 8];
    assign grant_onehot[gi] = (grant_reg == CHAN_W'(gi));
  end

  assign rr_ptr_next = (arb_grant == CHAN_W'(NUM_CHANNELS - 1)) ? '0 : arb_grant + 1'b1;
  assign cur_byte    = chan_bytes[grant_reg];
  assign cur_ovr     = overrun[grant_reg];
  assign header_byte = make_header(cur_ovr, 6'(grant_reg));
  assign xfer        = outvalid & outready;

  assign byteaddr     = byteaddr_reg;
  assign clearoverrun = clear_reg;
  assign busy         = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    outvalid   = 1'b0;
    outbyte    = 8'h00;
    unload     = '0;
    case (state_reg)
      IDLE: if (arb_found) state_next = HDR;
      HDR: begin
        outvalid = 1'b1;
        outbyte  = header_byte;
        if (outready) begin
`ifdef READOUT_CHECKSUM_EN
          state_next = cur_ovr ? CSUM : DATA;
`else
          state_next = cur_ovr ? HOLD : DATA;
`endif
        end
      end
      DATA: begin
        outvalid = 1'b1;
        outbyte  = cur_byte;
        if (outready && byteaddr_reg == LAST_ADDR) begin
`ifdef READOUT_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = UNLOAD;
`endif
        end
      end
`ifdef READOUT_CHECKSUM_EN
      CSUM: begin
        outvalid = 1'b1;
        outbyte  = csum_reg;
        if (outready) state_next = ovr_rec_reg ? HOLD : UNLOAD;
      end
`endif
      UNLOAD: begin
        unload     = grant_onehot;
        state_next = HOLD;
      end
      HOLD: if (hold_cnt_reg == 2'(HOLD_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      byteaddr_reg <= '0;
      clear_reg    <= '0;
      hold_cnt_reg <= '0;
`ifdef READOUT_CHECKSUM_EN
      csum_reg     <= '0;
      ovr_rec_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      clear_reg    <= '0;
      hold_cnt_reg <= (state_reg == HOLD) ? hold_cnt_reg + 2'd1 : 2'd0;
      if (state_reg == IDLE && arb_found) begin
        grant_reg  <= arb_grant;
        rr_ptr_reg <= rr_ptr_next;
      end
      if (state_reg == HDR && xfer) begin
        byteaddr_reg <= '0;
`ifdef READOUT_CHECKSUM_EN
        csum_reg    <= header_byte;
        ovr_rec_reg <= cur_ovr;
`else
        if (cur_ovr) clear_reg <= grant_onehot;
`endif
      end
      // byteaddr wraps 7 -> 0 on the final data transfer.
      if (state_reg == DATA && xfer) begin
        byteaddr_reg <= byteaddr_reg + 3'd1;
`ifdef READOUT_CHECKSUM_EN
        csum_reg     <= csum_reg ^ cur_byte;
`endif
      end
`ifdef READOUT_CHECKSUM_EN
      if (state_reg == CSUM && xfer && ovr_rec_reg) clear_reg <= grant_onehot;
`endif
    end
  end

endmodule
